piso_stream_ser: RTL and testbench

// - Parametrised parallel-in/serial-out serializer with valid/ready on both sides.
// - Generalises the fixed 4-bit PISO: adds WIDTH, per-word MSB/LSB-first order,
//   a one-word holding buffer for gapless back-to-back frames, and serial back-pressure.
// - Sits between a word-oriented producer and a 1-bit serial link or line driver.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_bit_counter.sv | 32 +++
 rtl/piso_stream_ser.sv | 151 +++++++++++++++
 tb/tb_piso_stream_ser.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream_ser serializer.
//   piso_state_t : serializer FSM state (IDLE = shifter empty, SHIFT = shifter holds a word)
//   cnt_w()      : width of a counter that must hold values 0..w-1
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, count -> 0
//   clr    : synchronous clear, count -> 0
//   en     : advance by one; wraps from MAX back to 0
//   count  : current bit index
//   at_max : count == MAX (current bit is the final one of the word)
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter  int MAX = 7,
    localparam int CW  = cnt_w(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          at_max
);

    assign at_max = (count == CW'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in / serial-out serializer with valid/ready on both sides, a
// one-word holding buffer for gapless back-to-back words, and per-word
// MSB-first / LSB-first ordering.
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset; aborts the current and held word
//   in         : parallel word
//   in_valid   : in / msb_first are valid
//   in_ready   : a word can be accepted this cycle
//   msb_first  : bit order of this word (1 = in[WIDTH-1] first), sampled on accept
//   out        : serial bit (IDLE_LEVEL while out_valid = 0)
//   out_valid  : out carries a valid bit
//   out_ready  : sink consumes out this cycle
//   out_last   : out is the final bit of its word
//   busy       : shifter or holding buffer occupied
//   dbg_state  : FSM state, for observation only
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both 1. A producer must hold data stable while valid=1 and ready=0. in_ready
// is derived from registered state and reset only, never from in_valid.
// While out_ready=0 the out, out_last and out_valid signals stay frozen.
module piso_stream_ser
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output piso_state_t      dbg_state
);

    localparam int CW = cnt_w(WIDTH);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $fatal(1, "piso_stream_ser: WIDTH must be in 2..64");
    end

    piso_state_t      state, state_nxt;
    logic [WIDTH-1:0] sh;
    logic             sh_msb;
    logic [WIDTH-1:0] hold;
    logic             hold_msb;
    logic             hold_full;
    logic [CW-1:0]    count;
    logic             at_max;
    logic             accept;
    logic             adv;
    logic             last_done;

    assign in_ready  = !hold_full && !reset;
    assign accept    = in_valid && in_ready;
    assign adv       = (state == SHIFT) && out_ready;
    assign last_done = adv && at_max;
    assign dbg_state = state;

    // Counter is held at 0 while idle so every word starts at bit 0.
    piso_bit_counter #(
        .MAX (WIDTH - 1)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == IDLE),
        .en     (adv),
        .count  (count),
        .at_max (at_max)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave SHIFT only when the last bit goes out and
    // nothing is waiting (neither held nor arriving on the same edge).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_done && !hold_full && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = 1'b0;
        out       = IDLE_LEVEL;
        out_last  = 1'b0;
        busy      = hold_full;
        if (state == SHIFT) begin
            out_valid = 1'b1;
            out       = sh_msb ? sh[WIDTH-1] : sh[0];
            out_last  = at_max;
            busy      = 1'b1;
        end
    end

    // Shifter and holding buffer. A word accepted while the shifter is busy
    // goes to the hold, except on the edge the last bit leaves with the hold
    // empty: then it bypasses straight into the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= '0;
            sh_msb    <= 1'b0;
            hold      <= '0;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            if (state == SHIFT && last_done && hold_full) begin
                hold_full <= 1'b0;
            end else if (state == SHIFT && accept && !last_done) begin
                hold      <= in;
                hold_msb  <= msb_first;
                hold_full <= 1'b1;
            end

            if (state == IDLE) begin
                if (accept) begin
                    sh     <= in;
                    sh_msb <= msb_first;
                end
            end else if (last_done) begin
                if (hold_full) begin
                    sh     <= hold;
                    sh_msb <= hold_msb;
                end else if (accept) begin
                    sh     <= in;
                    sh_msb <= msb_first;
                end else begin
                    sh <= '0;
                end
            end else if (adv) begin
                sh <= sh_msb ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_stream_ser.sv
// Self-checking bench for piso_stream_ser: a WIDTH=4 instance for the directed
// framing/stall cases and a WIDTH=8 instance for reset-abort and random traffic.
// Drivers push the expected {last, bit} sequence into a queue when a word is
// accepted; monitors pop and compare on every serial handshake.
module tb_piso_stream_ser;
    import piso_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance signals
    logic        rst4, iv4, ir4, msb4, o4, ov4, or4, ol4, busy4;
    logic [3:0]  in4;
    piso_state_t st4;
    // WIDTH=8 instance signals
    logic        rst8, iv8, ir8, msb8, o8, ov8, or8, ol8, busy8;
    logic [7:0]  in8;
    piso_state_t st8;

    int vectors     = 0;
    int miscompares = 0;
    int words8      = 0;
    int lasts8      = 0;
    bit rnd_on      = 1'b0;
    logic [7:0] rw;
    logic       rm;

    logic [1:0] exp4_q[$];
    logic [1:0] exp8_q[$];

    piso_stream_ser #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u_dut4 (
        .clk(clk), .reset(rst4), .in(in4), .in_valid(iv4), .in_ready(ir4),
        .msb_first(msb4), .out(o4), .out_valid(ov4), .out_ready(or4),
        .out_last(ol4), .busy(busy4), .dbg_state(st4)
    );

    piso_stream_ser #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk(clk), .reset(rst8), .in(in8), .in_valid(iv8), .in_ready(ir8),
        .msb_first(msb8), .out(o8), .out_valid(ov8), .out_ready(or8),
        .out_last(ol8), .busy(busy8), .dbg_state(st8)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Emission order for a WIDTH=8 word: seq[7] leaves first.
    function automatic logic [7:0] order8(input logic [7:0] w, input logic m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = m ? w[7-i] : w[i];
        return r;
    endfunction

    // Drivers are called just after a rising edge (+#1) and return likewise.
    // seq holds the bits in emission order, seq[W-1] first.
    task automatic send4(input logic [3:0] w, input logic m, input logic [3:0] seq);
        bit acc   = 1'b0;
        int guard = 0;
        in4 = w; msb4 = m; iv4 = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = ir4;
            @(posedge clk);
            guard++;
        end
        if (acc) begin
            for (int i = 3; i >= 0; i--) exp4_q.push_back({i == 0, seq[i]});
        end else begin
            checki("send4_accept_timeout", guard, -1);
        end
        #1 iv4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] w, input logic m, input logic [7:0] seq);
        bit acc   = 1'b0;
        int guard = 0;
        in8 = w; msb8 = m; iv8 = 1'b1;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = ir8;
            @(posedge clk);
            guard++;
        end
        if (acc) begin
            for (int i = 7; i >= 0; i--) exp8_q.push_back({i == 0, seq[i]});
            words8++;
        end else begin
            checki("send8_accept_timeout", guard, -1);
        end
        #1 iv8 = 1'b0;
    endtask

    // Monitors
    always @(negedge clk) begin
        if (!rst4 && ov4 && or4) begin
            vectors++;
            if (exp4_q.size() == 0) begin
                miscompares++;
                $display("FAIL mon4_unexpected_bit: got {last,bit}=%b%b expected none", ol4, o4);
            end else begin
                logic [1:0] e;
                e = exp4_q.pop_front();
                if ({ol4, o4} !== e) begin
                    miscompares++;
                    $display("FAIL mon4_bit: got {last,bit}=%b%b expected %b", ol4, o4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst8 && ov8 && or8) begin
            vectors++;
            if (ol8) lasts8++;
            if (exp8_q.size() == 0) begin
                miscompares++;
                $display("FAIL mon8_unexpected_bit: got {last,bit}=%b%b expected none", ol8, o8);
            end else begin
                logic [1:0] e;
                e = exp8_q.pop_front();
                if ({ol8, o8} !== e) begin
                    miscompares++;
                    $display("FAIL mon8_bit: got {last,bit}=%b%b expected %b", ol8, o8, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst4 = 1'b1; rst8 = 1'b1;
        iv4 = 1'b0; iv8 = 1'b0; in4 = '0; in8 = '0;
        msb4 = 1'b0; msb8 = 1'b0; or4 = 1'b1; or8 = 1'b1;

        // Reset
        @(posedge clk);
        @(negedge clk);
        check1("reset_in_ready_forced_low", ir4, 1'b0);
        @(posedge clk);
        #1 rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check1("reset_out_valid", ov4, 1'b0);
        check1("reset_out_idle", o4, 1'b0);
        check1("reset_out_last", ol4, 1'b0);
        check1("reset_busy", busy4, 1'b0);
        check1("reset_in_ready", ir4, 1'b1);
        checki("reset_state", int'(st4), int'(IDLE));
        check1("reset_out_valid8", ov8, 1'b0);
        @(posedge clk);
        #1;

        // 4'b1101 MSB-first -> 1,1,0,1
        send4(4'b1101, 1'b1, 4'b1101);
        @(negedge clk);
        check1("t1_first_bit_valid", ov4, 1'b1);
        repeat (3) @(negedge clk);
        check1("t1_last_on_bit4", ol4, 1'b1);
        @(negedge clk);
        check1("t1_idle_valid", ov4, 1'b0);
        check1("t1_idle_level", o4, 1'b0);
        check1("t1_idle_busy", busy4, 1'b0);
        @(posedge clk);
        #1;

        // 4'b1101 LSB-first -> 1,0,1,1
        send4(4'b1101, 1'b0, 4'b1011);
        repeat (5) @(negedge clk);
        check1("t2_idle_valid", ov4, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back 1010, 0110 MSB-first -> 1,0,1,0,0,1,1,0 contiguous
        send4(4'b1010, 1'b1, 4'b1010);
        send4(4'b0110, 1'b1, 4'b0110);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check1("t3_contiguous_valid", ov4, 1'b1);
            check1("t3_in_ready_vs_hold", ir4, (k > 4));
        end
        @(negedge clk);
        check1("t3_idle_valid", ov4, 1'b0);
        checki("t3_queue_empty", exp4_q.size(), 0);
        @(posedge clk);
        #1;

        // 4'b0100 MSB-first (0,1,0,0) with a 3-cycle stall during bit 2
        send4(4'b0100, 1'b1, 4'b0100);
        @(posedge clk);
        #1 or4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1("t4_stall_bit_frozen", o4, 1'b1);
            check1("t4_stall_last_frozen", ol4, 1'b0);
            check1("t4_stall_valid_frozen", ov4, 1'b1);
        end
        @(posedge clk);
        #1 or4 = 1'b1;
        repeat (3) @(negedge clk);
        check1("t4_last_at_cycle7", ol4, 1'b1);
        @(negedge clk);
        check1("t4_idle_after_7", ov4, 1'b0);
        checki("t4_queue_empty", exp4_q.size(), 0);
        @(posedge clk);
        #1;

        // 8'hA5 with 8'h81 held; reset after bit 2 aborts both
        send8(8'hA5, 1'b1, 8'hA5);
        send8(8'h81, 1'b0, 8'h81);
        @(negedge clk);
        check1("t5_hold_full_blocks", ir8, 1'b0);
        check1("t5_busy", busy8, 1'b1);
        @(posedge clk);
        #1 rst8 = 1'b1;
        exp8_q.delete();
        @(negedge clk);
        check1("t5_ready_low_in_reset", ir8, 1'b0);
        @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        check1("t5_after_reset_valid", ov8, 1'b0);
        check1("t5_after_reset_busy", busy8, 1'b0);
        check1("t5_after_reset_ready", ir8, 1'b1);
        check1("t5_after_reset_out", o8, 1'b0);
        @(posedge clk);
        #1;
        send8(8'h3C, 1'b1, 8'h3C);
        repeat (9) @(negedge clk);
        check1("t5_fresh_word_done", ov8, 1'b0);
        checki("t5_queue_empty", exp8_q.size(), 0);
        @(posedge clk);
        #1;

        // Random traffic, 1000 words
        words8 = 0;
        lasts8 = 0;
        rnd_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    rw = 8'($urandom);
                    rm = 1'($urandom_range(0, 1));
                    send8(rw, rm, order8(rw, rm));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 or8 = ($urandom_range(0, 3) != 0);
                end
                or8 = 1'b1;
            end
        join
        begin
            int g = 0;
            while ((busy8 || exp8_q.size() != 0) && g < 500) begin
                @(negedge clk);
                g++;
            end
            check1("t6_drain_in_time", (g < 500), 1'b1);
        end
        checki("t6_words_accepted", words8, 1000);
        checki("t6_last_count", lasts8, words8);
        checki("t6_queue_empty", exp8_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
